// File: rtl/rf_write_port.sv
// rf_write_port: write-side companion to the register file.
// Buffers write-back requests in a small FIFO and issues one register
// write per cycle as registered data (d) plus a one-hot strobe (dselect).
// The two read ports get combinational forwarding from every pending
// write, youngest first, so decode always sees the newest value.
module rf_write_port #(
    parameter int DEPTH = 2,    // FIFO entries, 1..4
    parameter int NREG  = 32    // number of registers, width of dselect (<= 32)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic [31:0]     in_data,
    input  logic            rf_hold,
    output logic [31:0]     d,
    output logic [NREG-1:0] dselect,
    input  logic [4:0]      qa_idx,
    input  logic [4:0]      qb_idx,
    output logic            qa_hit,
    output logic            qb_hit,
    output logic [31:0]     qa_fwd,
    output logic [31:0]     qb_fwd,
    output logic [2:0]      pending
);

    localparam logic [2:0] L_DEPTH = 3'(DEPTH);
    localparam logic [1:0] L_LAST  = 2'(DEPTH - 1);

    // Storage is always sized for the largest legal DEPTH so the 2-bit
    // pointers index it exactly; only slots 0..DEPTH-1 are ever used.
    logic [4:0]      r_mem_rd   [0:3];
    logic [31:0]     r_mem_data [0:3];
    logic [1:0]      r_head;
    logic [1:0]      r_tail;
    logic [2:0]      r_count;

    logic [31:0]     r_d;
    logic [NREG-1:0] r_dselect;
    logic [4:0]      r_issue_rd;
    logic            r_in_ready;
    logic [2:0]      r_pending;

    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [2:0]      w_count_nxt;
    logic [4:0]      w_head_rd;
    logic [31:0]     w_head_data;
    logic [31:0]     w_d_nxt;
    logic [NREG-1:0] w_dselect_nxt;
    logic [4:0]      w_issue_rd_nxt;
    logic            w_ready_nxt;
    logic [2:0]      w_pending_nxt;
    logic            w_qa_hit;
    logic            w_qb_hit;
    logic [31:0]     w_qa_fwd;
    logic [31:0]     w_qb_fwd;

    // Circular pointer advance that wraps at DEPTH (DEPTH need not be 2^n).
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        logic [1:0] n;
        if (p == L_LAST) begin
            n = 2'd0;
        end else begin
            n = p + 2'd1;
        end
        return n;
    endfunction

    // Slot holding the k-th oldest entry (k=0 is the head).
    function automatic logic [1:0] slot_of(input logic [1:0] head, input int k);
        logic [2:0] s;
        s = {1'b0, head} + 3'(k);
        if (s >= L_DEPTH) begin
            s = s - L_DEPTH;
        end else begin
            s = s;
        end
        return s[1:0];
    endfunction

    // One-hot strobe for a register index; register zero never gets a bit.
    function automatic logic [NREG-1:0] onehot(input logic [4:0] rd);
        logic [NREG-1:0] v;
        v = '0;
        for (int j = 1; j < NREG; j++) begin
            v[j] = (rd == 5'(j));
        end
        return v;
    endfunction

    // Handshake and FIFO occupancy. Writes to register zero complete the
    // handshake but never occupy a slot.
    assign w_accept    = in_valid & r_in_ready;
    assign w_push      = w_accept & (in_rd != 5'd0);
    assign w_pop       = ~rf_hold & (r_count != 3'd0);
    assign w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};
    assign w_head_rd   = r_mem_rd[r_head];
    assign w_head_data = r_mem_data[r_head];

    // Next issue state: freeze under hold, else pop head or go idle.
    always_comb begin
        w_d_nxt        = r_d;
        w_dselect_nxt  = r_dselect;
        w_issue_rd_nxt = r_issue_rd;
        if (rf_hold) begin
            w_d_nxt        = r_d;
            w_dselect_nxt  = r_dselect;
            w_issue_rd_nxt = r_issue_rd;
        end else if (r_count != 3'd0) begin
            w_d_nxt        = w_head_data;
            w_dselect_nxt  = onehot(w_head_rd);
            w_issue_rd_nxt = w_head_rd;
        end else begin
            w_d_nxt        = r_d;
            w_dselect_nxt  = '0;
            w_issue_rd_nxt = r_issue_rd;
        end
    end

    // Ready and pending are registered views of the next-state occupancy,
    // so neither has a combinational path from in_valid or the pop.
    assign w_ready_nxt   = (w_count_nxt < L_DEPTH);
    assign w_pending_nxt = w_count_nxt + {2'b00, (|w_dselect_nxt)};

    // FIFO storage: capture accepted non-zero-register requests at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_mem_rd[i]   <= 5'd0;
                r_mem_data[i] <= 32'd0;
            end
        end else if (w_push) begin
            r_mem_rd[r_tail]   <= in_rd;
            r_mem_data[r_tail] <= in_data;
        end
    end

    // FIFO pointers and count; reset discards everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            r_count <= w_count_nxt;
        end
    end

    // Issue registers and registered status; reset kills the write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d        <= 32'd0;
            r_dselect  <= '0;
            r_issue_rd <= 5'd0;
            r_in_ready <= 1'b0;
            r_pending  <= 3'd0;
        end else begin
            r_d        <= w_d_nxt;
            r_dselect  <= w_dselect_nxt;
            r_issue_rd <= w_issue_rd_nxt;
            r_in_ready <= w_ready_nxt;
            r_pending  <= w_pending_nxt;
        end
    end

    // Forwarding search, oldest first so younger matches overwrite older:
    // issuing entry, then FIFO head .. tail-1. Index zero never hits.
    always_comb begin
        w_qa_hit = 1'b0;
        w_qb_hit = 1'b0;
        w_qa_fwd = 32'd0;
        w_qb_fwd = 32'd0;
        if ((|r_dselect) && (r_issue_rd == qa_idx) && (qa_idx != 5'd0)) begin
            w_qa_hit = 1'b1;
            w_qa_fwd = r_d;
        end else begin
            w_qa_hit = 1'b0;
        end
        if ((|r_dselect) && (r_issue_rd == qb_idx) && (qb_idx != 5'd0)) begin
            w_qb_hit = 1'b1;
            w_qb_fwd = r_d;
        end else begin
            w_qb_hit = 1'b0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(r_count)) begin
                if ((r_mem_rd[slot_of(r_head, k)] == qa_idx) && (qa_idx != 5'd0)) begin
                    w_qa_hit = 1'b1;
                    w_qa_fwd = r_mem_data[slot_of(r_head, k)];
                end else begin
                    w_qa_fwd = w_qa_fwd;
                end
                if ((r_mem_rd[slot_of(r_head, k)] == qb_idx) && (qb_idx != 5'd0)) begin
                    w_qb_hit = 1'b1;
                    w_qb_fwd = r_mem_data[slot_of(r_head, k)];
                end else begin
                    w_qb_fwd = w_qb_fwd;
                end
            end else begin
                w_qa_fwd = w_qa_fwd;
            end
        end
    end

    assign in_ready = r_in_ready;
    assign d        = r_d;
    assign dselect  = r_dselect;
    assign pending  = r_pending;
    assign qa_hit   = w_qa_hit;
    assign qb_hit   = w_qb_hit;
    assign qa_fwd   = w_qa_fwd;
    assign qb_fwd   = w_qb_fwd;

endmodule

// File: tb/tb_rf_write_port.sv
// Directed testbench for rf_write_port: expected writes go into a
// scoreboard queue when a request is accepted and are checked when the
// DUT issues them.
module tb_rf_write_port;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        rf_hold;
    logic [31:0] d;
    logic [31:0] dselect;
    logic [4:0]  qa_idx;
    logic [4:0]  qb_idx;
    logic        qa_hit;
    logic        qb_hit;
    logic [31:0] qa_fwd;
    logic [31:0] qb_fwd;
    logic [2:0]  pending;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t sbq[$];
    int   total;
    int   bad;
    logic hold_q;

    rf_write_port #(.DEPTH(2), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data),
        .rf_hold(rf_hold),
        .d(d), .dselect(dselect),
        .qa_idx(qa_idx), .qb_idx(qb_idx),
        .qa_hit(qa_hit), .qb_hit(qb_hit),
        .qa_fwd(qa_fwd), .qb_fwd(qb_fwd),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare a freshly issued write against the scoreboard head.
    task automatic mon();
        ent_t        e;
        logic [31:0] sel;
        if (dselect != 32'd0 && !hold_q) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_write observed=%h expected=%h", dselect, 32'd0);
            end else begin
                e   = sbq.pop_front();
                sel = 32'd1 << e.rd;
                chk("wr_sel", dselect, sel);
                chk("wr_data", d, e.data);
            end
        end
    endtask

    // One clock: record acceptance at the edge, then check at the falling edge.
    task automatic cyc();
        logic acc;
        ent_t e;
        acc = in_valid && in_ready && rst_n;
        e.rd   = in_rd;
        e.data = in_data;
        @(posedge clk);
        hold_q = rf_hold;
        if (acc && e.rd != 5'd0) sbq.push_back(e);
        @(negedge clk);
        mon();
    endtask

    // Present a request and hold it until accepted, bounded.
    task automatic send(input logic [4:0] rd, input logic [31:0] data);
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_rd    = rd;
        in_data  = data;
        for (int n = 0; n < 20 && !done; n++) begin
            done = in_ready;
            cyc();
        end
        chk("send_accept", {31'd0, done}, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; hold_q = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_rd = 5'd0; in_data = 32'd0;
        rf_hold = 1'b0; qa_idx = 5'd0; qb_idx = 5'd0;

        // Reset state
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_dsel", dselect, 32'd0);
        chk("rst_d", d, 32'd0);
        chk("rst_pending", {29'd0, pending}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // 1: single write latency
        in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hDEADBEEF;
        cyc();
        in_valid = 1'b0;
        chk("t1_pend_a", {29'd0, pending}, 32'd1);
        chk("t1_dsel_a", dselect, 32'd0);
        cyc();
        chk("t1_dsel_b", dselect, 32'h0000_0020);
        chk("t1_d_b", d, 32'hDEADBEEF);
        chk("t1_pend_b", {29'd0, pending}, 32'd1);
        cyc();
        chk("t1_dsel_c", dselect, 32'd0);
        chk("t1_pend_c", {29'd0, pending}, 32'd0);

        // 2: three back-to-back requests, FIFO fills
        rf_hold = 1'b1;
        in_valid = 1'b1; in_rd = 5'd1; in_data = 32'hA1;
        cyc();
        in_rd = 5'd2; in_data = 32'hA2;
        cyc();
        chk("t2_full_ready", {31'd0, in_ready}, 32'd0);
        chk("t2_pend_full", {29'd0, pending}, 32'd2);
        in_rd = 5'd3; in_data = 32'hA3; rf_hold = 1'b0;
        cyc();
        chk("t2_first", dselect, 32'h0000_0002);
        chk("t2_ready_back", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("t2_second", dselect, 32'h0000_0004);
        cyc();
        chk("t2_third", dselect, 32'h0000_0008);
        cyc();
        chk("t2_idle", dselect, 32'd0);
        chk("t2_pend_idle", {29'd0, pending}, 32'd0);

        // 3: register zero is dropped
        send(5'd0, 32'hFFFFFFFF);
        chk("t3_pend", {29'd0, pending}, 32'd0);
        cyc();
        chk("t3_dsel", dselect, 32'd0);
        chk("t3_pend2", {29'd0, pending}, 32'd0);
        qa_idx = 5'd0; qb_idx = 5'd0; #1;
        chk("t3_qa_hit", {31'd0, qa_hit}, 32'd0);
        chk("t3_qa_fwd", qa_fwd, 32'd0);

        // 4: forwarding youngest of two pending writes to r7
        rf_hold = 1'b1;
        send(5'd7, 32'h11);
        send(5'd7, 32'h22);
        qa_idx = 5'd7; qb_idx = 5'd5; #1;
        chk("t4_qa_hit", {31'd0, qa_hit}, 32'd1);
        chk("t4_qa_fwd", qa_fwd, 32'h22);
        chk("t4_qb_hit", {31'd0, qb_hit}, 32'd0);
        chk("t4_qb_fwd", qb_fwd, 32'd0);
        chk("t4_pend", {29'd0, pending}, 32'd2);
        rf_hold = 1'b0;
        cyc();
        chk("t4_w1_d", d, 32'h11);
        chk("t4_fwd_mix", qa_fwd, 32'h22);
        cyc();
        chk("t4_w2_d", d, 32'h22);
        chk("t4_fwd_issue", qa_fwd, 32'h22);
        cyc();
        chk("t4_nohit", {31'd0, qa_hit}, 32'd0);

        // 5: hold freezes an issuing write and the FIFO
        in_valid = 1'b1; in_rd = 5'd4; in_data = 32'h44;
        cyc();
        in_rd = 5'd9; in_data = 32'h99;
        cyc();
        in_valid = 1'b0; rf_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_dsel_hold", dselect, 32'h0000_0010);
            chk("t5_d_hold", d, 32'h44);
            chk("t5_pend_hold", {29'd0, pending}, 32'd2);
        end
        rf_hold = 1'b0;
        cyc();
        chk("t5_after", dselect, 32'h0000_0200);
        cyc();

        // 6: async reset with two queued plus one issuing
        rf_hold = 1'b1;
        send(5'd10, 32'hB10);
        send(5'd11, 32'hB11);
        rf_hold = 1'b0;
        cyc();
        rf_hold = 1'b1;
        send(5'd12, 32'hB12);
        chk("t6_pend3", {29'd0, pending}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_dsel_rst", dselect, 32'd0);
        chk("t6_d_rst", d, 32'd0);
        chk("t6_pend_rst", {29'd0, pending}, 32'd0);
        chk("t6_ready_rst", {31'd0, in_ready}, 32'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1; rf_hold = 1'b0;
        repeat (4) cyc();
        chk("t6_dsel_post", dselect, 32'd0);
        chk("t6_pend_post", {29'd0, pending}, 32'd0);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
